obi_boot_loader: RTL and testbench

Bus initiator that loads a program image into a word-addressed memory over the core-side request/grant/rvalid memory protocol, as used between the fault-tolerant core and `sp_ram`. It accepts a byte stream via a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them to consecutive addresses from `BASE_ADDR`. One transaction is outstanding at a time. When the image is written without error, it raises `fetch_enable_o` to release the core from boot stall. It sits in the SoC next to the core, muxed onto the instruction memory port during boot.

---
 rtl/obi_boot_loader.sv | 155 +++++++++++++++
 tb/tb_obi_boot_loader.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_boot_loader.sv
`default_nettype none
// obi_boot_loader: packs a little-endian byte stream into 32-bit words and writes
// them over a req/gnt/rvalid memory port, then releases the core. Rev 1.0
module obi_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned MAX_WORDS  = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [15:0]           num_words_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic                  err_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  output logic [31:0]           wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  fetch_enable_o,
  output logic [15:0]           words_written_o
);

  localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [15:0]             count;
  logic [15:0]             words_written;
  logic [1:0]              byte_idx;
  logic [31:0]             word;
  logic                    error;
  logic [15:0]             start_count;
  logic [ADDR_WIDTH-1:0]   addr_calc;

  assign start_count = (num_words_i > MAX_COUNT) ? MAX_COUNT : num_words_i;
  // Address wraps silently at ADDR_WIDTH.
  assign addr_calc   = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({words_written, 2'b00});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    byte_ready_o    = 1'b0;
    req_o           = 1'b0;
    we_o            = 1'b0;
    be_o            = 4'b0000;
    wdata_o         = 32'h0;
    addr_o          = '0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    error_o         = error;
    fetch_enable_o  = 1'b0;
    words_written_o = words_written;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = (start_count == 16'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i && (byte_idx == 2'd3)) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'b1111;
        wdata_o = word;
        addr_o  = addr_calc;
        busy_o  = 1'b1;
        if (gnt_i) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (rvalid_i) begin
          if (err_i) begin
            state_next = S_DONE;
          end else if ((words_written + 16'd1) == count) begin
            state_next = S_DONE;
          end else begin
            state_next = S_COLLECT;
          end
        end
      end
      S_DONE: begin
        done_o         = 1'b1;
        fetch_enable_o = ~error;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count         <= 16'd0;
      words_written <= 16'd0;
      byte_idx      <= 2'd0;
      word          <= 32'h0;
      error         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          byte_idx <= 2'd0;
          if (start_i) begin
            count <= start_count;
          end
        end
        S_COLLECT: begin
          if (byte_valid_i) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_data_i;
            byte_idx                      <= byte_idx + 2'd1;
          end
        end
        S_WAIT: begin
          if (rvalid_i) begin
            words_written <= words_written + 16'd1;
            if (err_i) begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_boot_loader.sv
`default_nettype none
// tb_obi_boot_loader: directed tests with a simple grant/response memory model.
module tb_obi_boot_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] num_words_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        req_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic        err_i;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        fetch_enable_o;
  logic [15:0] words_written_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // memory model state (written only by the responder)
  int          wr_cnt    = 0;
  logic [31:0] wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          bad_bus   = 0;
  int          ready_bad = 0;
  int          stall_left = 0;
  bit          pending   = 0;
  bit          pend_err  = 0;
  bit          prev_req  = 0;
  // memory model controls (written only by the main sequence)
  int          stall_cfg = 0;
  int          err_at    = -1;

  obi_boot_loader dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .num_words_i     (num_words_i),
    .byte_valid_i    (byte_valid_i),
    .byte_data_i     (byte_data_i),
    .byte_ready_o    (byte_ready_o),
    .req_o           (req_o),
    .gnt_i           (gnt_i),
    .rvalid_i        (rvalid_i),
    .err_i           (err_i),
    .addr_o          (addr_o),
    .we_o            (we_o),
    .be_o            (be_o),
    .wdata_o         (wdata_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .fetch_enable_o  (fetch_enable_o),
    .words_written_o (words_written_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder: drives on the falling edge, one-cycle response after grant.
  initial begin
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    err_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        pending  = 1'b0;
        prev_req = 1'b0;
      end else begin
        rvalid_i = pending;
        err_i    = pending && pend_err;
        pending  = 1'b0;
        if (!req_o && (we_o !== 1'b0 || be_o !== 4'h0 || wdata_o !== 32'h0)) bad_bus++;
        if (req_o) begin
          if (be_o !== 4'hF || we_o !== 1'b1) bad_bus++;
          if (byte_ready_o) ready_bad++;
          if (!prev_req) stall_left = stall_cfg;
          if (stall_left > 0) begin
            gnt_i = 1'b0;
            stall_left--;
          end else begin
            gnt_i = 1'b1;
            if (wr_cnt < 1024) begin
              wr_addr[wr_cnt] = addr_o;
              wr_data[wr_cnt] = wdata_o;
            end
            pend_err = (wr_cnt == err_at);
            pending  = 1'b1;
            wr_cnt++;
          end
        end else begin
          gnt_i = 1'b0;
        end
        prev_req = req_o;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic do_reset;
    @(negedge clk_i);
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] n);
    @(negedge clk_i);
    start_i     = 1'b1;
    num_words_i = n;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Offers nb bytes of w (LSB first); returns one cycle after the last acceptance.
  task automatic send_word(input logic [31:0] w, input int nb, input bit gaps);
    for (int k = 0; k < nb; k++) begin
      bit acc;
      int budget;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 300) begin
        @(negedge clk_i);
        budget++;
        if (gaps && $urandom_range(0, 2) == 0) begin
          byte_valid_i = 1'b0;
        end else begin
          byte_valid_i = 1'b1;
          byte_data_i  = w[8*k +: 8];
          acc          = byte_ready_o;
        end
      end
      if (!acc) begin
        n_asserts++; n_fail++;
        $display("FAIL send_byte_timeout: byte %0d ready=%b, required accepted", k, byte_ready_o);
      end
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    if (!done_o) begin
      n_asserts++; n_fail++;
      $display("FAIL wait_done_timeout: done_o=%b after %0d cycles, required 1", done_o, i);
    end
  endtask

  task automatic test_reset;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    num_words_i  = 16'd0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_asserts++;
    if ({req_o, we_o, be_o, byte_ready_o, busy_o, done_o, error_o, fetch_enable_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected all 0",
               {req_o, we_o, be_o, byte_ready_o, busy_o, done_o, error_o, fetch_enable_o});
    end
    n_asserts++;
    if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", addr_o); end
    n_asserts++;
    if (wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h, expected 0", wdata_o); end
    n_asserts++;
    if (words_written_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_words: got %0d, expected 0", words_written_o);
    end
  endtask

  task automatic test_basic;
    int wb;
    do_reset();
    stall_cfg = 0;
    wb = wr_cnt;
    start_load(16'd2);
    n_asserts++;
    if (byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b, expected 1", byte_ready_o); end
    send_word(32'h44332211, 4, 1'b0);
    n_asserts++;
    if ({req_o, addr_o, wdata_o} !== {1'b1, 32'h0, 32'h44332211}) begin
      n_fail++; $display("FAIL basic_req_latency: got req=%b addr=%h data=%h, expected 1 0 44332211",
                         req_o, addr_o, wdata_o);
    end
    send_word(32'h88776655, 4, 1'b0);
    wait_done(50);
    n_asserts++;
    if (wr_cnt - wb !== 2) begin n_fail++; $display("FAIL basic_nwrites: got %0d, expected 2", wr_cnt - wb); end
    n_asserts++;
    if ({wr_addr[wb], wr_data[wb]} !== {32'h0, 32'h44332211}) begin
      n_fail++; $display("FAIL basic_word0: got %h@%h, expected 44332211@0", wr_data[wb], wr_addr[wb]);
    end
    n_asserts++;
    if ({wr_addr[wb+1], wr_data[wb+1]} !== {32'h4, 32'h88776655}) begin
      n_fail++; $display("FAIL basic_word1: got %h@%h, expected 88776655@4", wr_data[wb+1], wr_addr[wb+1]);
    end
    n_asserts++;
    if ({done_o, fetch_enable_o, error_o, busy_o} !== 4'b1100) begin
      n_fail++; $display("FAIL basic_status: got done/fe/err/busy=%b, expected 1100",
                         {done_o, fetch_enable_o, error_o, busy_o});
    end
    n_asserts++;
    if (words_written_o !== 16'd2) begin
      n_fail++; $display("FAIL basic_words: got %0d, expected 2", words_written_o);
    end
    n_asserts++;
    if (bad_bus !== 0) begin n_fail++; $display("FAIL bus_we_be: got %0d bad cycles, expected 0", bad_bus); end
  endtask

  task automatic test_grant_stall;
    int wb;
    do_reset();
    stall_cfg = 5;
    wb = wr_cnt;
    start_load(16'd1);
    send_word(32'hDEADBEEF, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_asserts++;
      if ({req_o, addr_o, wdata_o} !== {1'b1, 32'h0, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL stall_stable cyc%0d: got req=%b addr=%h data=%h, expected 1 0 deadbeef",
                           i, req_o, addr_o, wdata_o);
      end
      @(negedge clk_i);
    end
    wait_done(50);
    stall_cfg = 0;
    n_asserts++;
    if (wr_cnt - wb !== 1) begin n_fail++; $display("FAIL stall_nwrites: got %0d, expected 1", wr_cnt - wb); end
    n_asserts++;
    if (wr_data[wb] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stall_data: got %h, expected deadbeef", wr_data[wb]);
    end
  endtask

  task automatic test_stream_gaps;
    int wb;
    int rb;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09;
    do_reset();
    stall_cfg = 2;
    wb = wr_cnt;
    rb = ready_bad;
    start_load(16'd3);
    for (int i = 0; i < 3; i++) send_word(exp_w[i], 4, 1'b1);
    wait_done(100);
    stall_cfg = 0;
    n_asserts++;
    if (wr_cnt - wb !== 3) begin n_fail++; $display("FAIL gaps_nwrites: got %0d, expected 3", wr_cnt - wb); end
    for (int i = 0; i < 3; i++) begin
      n_asserts++;
      if ({wr_addr[wb+i], wr_data[wb+i]} !== {32'(4*i), exp_w[i]}) begin
        n_fail++; $display("FAIL gaps_word%0d: got %h@%h, expected %h@%h",
                           i, wr_data[wb+i], wr_addr[wb+i], exp_w[i], 4*i);
      end
    end
    n_asserts++;
    if (ready_bad - rb !== 0) begin
      n_fail++; $display("FAIL gaps_ready_in_req: got %0d cycles, expected 0", ready_bad - rb);
    end
  endtask

  task automatic test_error;
    int wb;
    int bad;
    do_reset();
    wb = wr_cnt;
    err_at = wr_cnt;
    start_load(16'd3);
    send_word(32'hA4A3A2A1, 4, 1'b0);
    wait_done(50);
    err_at = -1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      byte_valid_i = 1'b1;
      byte_data_i  = 8'h5A;
      if (byte_ready_o || req_o) bad++;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    n_asserts++;
    if ({done_o, error_o, fetch_enable_o} !== 3'b110) begin
      n_fail++; $display("FAIL error_status: got done/err/fe=%b, expected 110", {done_o, error_o, fetch_enable_o});
    end
    n_asserts++;
    if (words_written_o !== 16'd1) begin
      n_fail++; $display("FAIL error_words: got %0d, expected 1", words_written_o);
    end
    n_asserts++;
    if (wr_cnt - wb !== 1 || bad !== 0) begin
      n_fail++; $display("FAIL error_no_more_req: got writes=%0d busy_cycles=%0d, expected 1 and 0",
                         wr_cnt - wb, bad);
    end
  endtask

  task automatic test_zero_words;
    int wb;
    int bad;
    do_reset();
    wb = wr_cnt;
    start_load(16'd0);
    n_asserts++;
    if ({done_o, fetch_enable_o, busy_o} !== 3'b110) begin
      n_fail++; $display("FAIL zero_done_next: got done/fe/busy=%b, expected 110", {done_o, fetch_enable_o, busy_o});
    end
    start_load(16'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      byte_valid_i = 1'b1;
      byte_data_i  = 8'hC3;
      if (byte_ready_o || req_o || !done_o) bad++;
    end
    byte_valid_i = 1'b0;
    n_asserts++;
    if (wr_cnt - wb !== 0 || bad !== 0) begin
      n_fail++; $display("FAIL zero_ignore_start: got writes=%0d bad=%0d, expected 0 and 0", wr_cnt - wb, bad);
    end
  endtask

  task automatic test_clamp;
    int wb;
    int bad;
    do_reset();
    wb = wr_cnt;
    start_load(16'd600);
    for (int i = 0; i < 512; i++) send_word(32'hC0DE0000 | 32'(i), 4, 1'b0);
    wait_done(50);
    repeat (10) @(negedge clk_i);
    n_asserts++;
    if (wr_cnt - wb !== 512) begin n_fail++; $display("FAIL clamp_nwrites: got %0d, expected 512", wr_cnt - wb); end
    n_asserts++;
    if (wr_addr[wb+511] !== 32'h7FC) begin
      n_fail++; $display("FAIL clamp_last_addr: got %h, expected 000007fc", wr_addr[wb+511]);
    end
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (wr_addr[wb+i] !== 32'(4*i) || wr_data[wb+i] !== (32'hC0DE0000 | 32'(i))) bad++;
    end
    n_asserts++;
    if (bad !== 0) begin n_fail++; $display("FAIL clamp_contents: got %0d wrong words, expected 0", bad); end
    n_asserts++;
    if ({words_written_o, fetch_enable_o} !== {16'd512, 1'b1}) begin
      n_fail++; $display("FAIL clamp_words: got %0d fe=%b, expected 512 fe=1", words_written_o, fetch_enable_o);
    end
  endtask

  task automatic test_mid_reset;
    int wb;
    do_reset();
    start_load(16'd2);
    send_word(32'h13121110, 4, 1'b0);
    send_word(32'h17161514, 2, 1'b0);
    n_asserts++;
    if (words_written_o !== 16'd1) begin
      n_fail++; $display("FAIL midrst_pre_words: got %0d, expected 1", words_written_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_asserts++;
    if ({req_o, we_o, be_o, byte_ready_o, busy_o, done_o, error_o, fetch_enable_o, addr_o, wdata_o,
         words_written_o} !== 91'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got ready=%b busy=%b words=%0d addr=%h data=%h, expected all 0",
                         byte_ready_o, busy_o, words_written_o, addr_o, wdata_o);
    end
    rst_i = 1'b0;
    wb = wr_cnt;
    start_load(16'd1);
    send_word(32'hCAFEF00D, 4, 1'b0);
    wait_done(50);
    n_asserts++;
    if (wr_cnt - wb !== 1 || wr_addr[wb] !== 32'h0 || wr_data[wb] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL midrst_fresh_write: got n=%0d %h@%h, expected 1 cafef00d@0",
                         wr_cnt - wb, wr_data[wb], wr_addr[wb]);
    end
    n_asserts++;
    if ({words_written_o, fetch_enable_o} !== {16'd1, 1'b1}) begin
      n_fail++; $display("FAIL midrst_words: got %0d fe=%b, expected 1 fe=1", words_written_o, fetch_enable_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_stall();
    test_stream_gaps();
    test_error();
    test_zero_words();
    test_clamp();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
